segcap: RTL and testbench

//   Receive end of the 4-digit multiplexed 7-segment bus. Samples the seg_pins/segen

---
 rtl/segcap.sv | 163 ++++++++++++++++
 tb/tb_segcap.sv | 379 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/segcap.sv
// rtl/segcap.sv - receive side of the 4-digit multiplexed 7-segment bus; rebuilds the 28-bit digit word.
// Optional SEGCAP_ORDER_CHECK_EN: digits must arrive in order 0,1,2,3.
module segcap #(
    parameter int STABLE_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  seg_pins,
    input  logic [3:0]  segen,
    output logic [27:0] seg,
    output logic        frame_valid,
    output logic        seg_err,
    output logic [7:0]  err_cnt,
    output logic [3:0]  digit_seen
);
    localparam logic [3:0] STABLE_N = 4'(STABLE_CYCLES);

    logic [6:0]  s_pins;
    logic [3:0]  s_en;
    logic [3:0]  run_cnt;
    logic        run_done;
    logic [27:0] shadow;

    logic        changed;
    logic        accept;
    logic        legal;
    logic [1:0]  dig;
    logic [3:0]  dig_bit;
    logic [27:0] merged;
    logic        ord_bad;

    logic [27:0] shadow_n;
    logic [27:0] seg_n;
    logic [3:0]  seen_n;
    logic        fv_n;
    logic        err_n;
    logic [7:0]  err_cnt_n;

`ifdef SEGCAP_ORDER_CHECK_EN
    logic [1:0]  exp_idx;
    logic [1:0]  exp_n;
    assign ord_bad = (dig != exp_idx);
`else
    assign ord_bad = 1'b0;
`endif

    assign changed = ({seg_pins, segen} != {s_pins, s_en});
    // run_done blocks a second accept once the counter parks at its saturation value
    assign accept  = (run_cnt == STABLE_N) && !run_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            s_pins   <= '0;
            s_en     <= '0;
            run_cnt  <= '0;
            run_done <= 1'b0;
        end else begin
            s_pins <= seg_pins;
            s_en   <= segen;
            if (changed) begin
                run_cnt  <= 4'd1;
                run_done <= 1'b0;
            end else begin
                if (run_cnt != 4'hF) begin
                    run_cnt <= run_cnt + 4'd1;
                end
                if (accept) begin
                    run_done <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        legal = 1'b1;
        dig   = 2'd0;
        case (s_en)
            4'b1110: dig = 2'd0;
            4'b1101: dig = 2'd1;
            4'b1011: dig = 2'd2;
            4'b0111: dig = 2'd3;
            default: legal = 1'b0;
        endcase
        dig_bit = 4'b0001 << dig;
        merged  = shadow;
        case (dig)
            2'd0:    merged[6:0]   = s_pins;
            2'd1:    merged[13:7]  = s_pins;
            2'd2:    merged[20:14] = s_pins;
            default: merged[27:21] = s_pins;
        endcase
    end

    always_comb begin
        shadow_n = shadow;
        seg_n    = seg;
        seen_n   = digit_seen;
        fv_n     = 1'b0;
        err_n    = 1'b0;
`ifdef SEGCAP_ORDER_CHECK_EN
        exp_n    = exp_idx;
`endif
        // blank samples (all enables high) are idle bus time, not errors
        if (accept && (s_en != 4'hF)) begin
            if (!legal) begin
                err_n  = 1'b1;
                seen_n = 4'b0000;
`ifdef SEGCAP_ORDER_CHECK_EN
                exp_n  = 2'd0;
`endif
            end else if (ord_bad) begin
                err_n  = 1'b1;
                seen_n = 4'b0000;
`ifdef SEGCAP_ORDER_CHECK_EN
                exp_n  = 2'd0;
                if (dig == 2'd0) begin
                    shadow_n = merged;
                    seen_n   = 4'b0001;
                    exp_n    = 2'd1;
                end
`endif
            end else begin
                shadow_n = merged;
`ifdef SEGCAP_ORDER_CHECK_EN
                exp_n    = exp_idx + 2'd1;
`endif
                if ((digit_seen | dig_bit) == 4'hF) begin
                    seg_n  = merged;
                    fv_n   = 1'b1;
                    seen_n = 4'b0000;
                end else begin
                    seen_n = digit_seen | dig_bit;
                end
            end
        end
        err_cnt_n = (err_n && (err_cnt != 8'hFF)) ? err_cnt + 8'd1 : err_cnt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shadow      <= '0;
            seg         <= '0;
            frame_valid <= 1'b0;
            seg_err     <= 1'b0;
            err_cnt     <= '0;
            digit_seen  <= '0;
`ifdef SEGCAP_ORDER_CHECK_EN
            exp_idx     <= '0;
`endif
        end else begin
            shadow      <= shadow_n;
            seg         <= seg_n;
            frame_valid <= fv_n;
            seg_err     <= err_n;
            err_cnt     <= err_cnt_n;
            digit_seen  <= seen_n;
`ifdef SEGCAP_ORDER_CHECK_EN
            exp_idx     <= exp_n;
`endif
        end
    end

endmodule

// File: tb/tb_segcap.sv
// tb/tb_segcap.sv - bench for segcap; two instances (STABLE_CYCLES 1 and 3) against a sample-level reference model.
module tb_segcap;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst  = 1'b1;
    logic [6:0]  pins = '0;
    logic [3:0]  en   = 4'hF;
    logic [27:0] o_seg [2];
    logic        o_fv  [2];
    logic        o_err [2];
    logic [7:0]  o_ec  [2];
    logic [3:0]  o_ds  [2];

    segcap #(.STABLE_CYCLES(1)) u_s1 (
        .clk(clk), .rst(rst), .seg_pins(pins), .segen(en), .seg(o_seg[0]),
        .frame_valid(o_fv[0]), .seg_err(o_err[0]), .err_cnt(o_ec[0]), .digit_seen(o_ds[0])
    );
    segcap #(.STABLE_CYCLES(3)) u_s3 (
        .clk(clk), .rst(rst), .seg_pins(pins), .segen(en), .seg(o_seg[1]),
        .frame_valid(o_fv[1]), .seg_err(o_err[1]), .err_cnt(o_ec[1]), .digit_seen(o_ds[1])
    );

    int errors = 0;
    int checks = 0;

    int          stab  [2] = '{1, 3};
    logic [10:0] m_prev [2];
    int          m_run  [2];
    bit          m_pend [2];
    logic [10:0] m_smp  [2];
    logic [6:0]  m_val  [2][4];
    bit          m_got  [2][4];
    int          m_exp  [2];
    logic [27:0] x_seg  [2];
    bit          x_fv   [2];
    bit          x_err  [2];
    int          x_ec   [2];

    function automatic logic [41:0] got_vec(input int i);
        return {o_seg[i], o_fv[i], o_err[i], o_ec[i], o_ds[i]};
    endfunction

    function automatic logic [41:0] exp_vec(input int i);
        logic [3:0] ds;
        for (int d = 0; d < 4; d++) ds[d] = m_got[i][d];
        return {x_seg[i], x_fv[i], x_err[i], 8'(x_ec[i]), ds};
    endfunction

    task automatic clear_frame(input int i);
        for (int d = 0; d < 4; d++) m_got[i][d] = 1'b0;
        m_exp[i] = 0;
    endtask

    task automatic model_reset(input int i);
        m_prev[i] = '0; m_run[i] = 0; m_pend[i] = 1'b0; m_smp[i] = '0;
        x_seg[i] = '0; x_fv[i] = 1'b0; x_err[i] = 1'b0; x_ec[i] = 0;
        for (int d = 0; d < 4; d++) m_val[i][d] = '0;
        clear_frame(i);
    endtask

    task automatic flag_err(input int i);
        x_err[i] = 1'b1;
        if (x_ec[i] < 255) x_ec[i]++;
        clear_frame(i);
    endtask

    // Effect of the sample accepted on the previous edge, as seen on the outputs now
    task automatic model_apply(input int i);
        logic [6:0] p;
        logic [3:0] e;
        int zeros;
        int d;
        x_fv[i] = 1'b0;
        x_err[i] = 1'b0;
        if (!m_pend[i]) return;
        p = m_smp[i][10:4];
        e = m_smp[i][3:0];
        if (e == 4'hF) return;
        zeros = 0;
        d = 0;
        for (int b = 0; b < 4; b++) if (!e[b]) begin zeros++; d = b; end
        if (zeros != 1) begin
            flag_err(i);
            return;
        end
`ifdef SEGCAP_ORDER_CHECK_EN
        if (d != m_exp[i]) begin
            flag_err(i);
            if (d == 0) begin m_val[i][0] = p; m_got[i][0] = 1'b1; m_exp[i] = 1; end
            return;
        end
`endif
        m_val[i][d] = p;
        m_got[i][d] = 1'b1;
        m_exp[i] = (m_exp[i] + 1) % 4;
        if (m_got[i][0] && m_got[i][1] && m_got[i][2] && m_got[i][3]) begin
            x_seg[i] = {m_val[i][3], m_val[i][2], m_val[i][1], m_val[i][0]};
            x_fv[i] = 1'b1;
            clear_frame(i);
        end
    endtask

    task automatic step(input logic [6:0] p, input logic [3:0] e);
        pins = p;
        en = e;
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                model_reset(i);
            end else begin
                model_apply(i);
                if ({p, e} != m_prev[i]) m_run[i] = 1; else m_run[i]++;
                m_prev[i] = {p, e};
                m_smp[i] = {p, e};
                m_pend[i] = (m_run[i] == stab[i]);
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(7'h00, 4'hF);
        step(7'h00, 4'hF);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (got_vec(i) !== 42'd0) begin
                errors++;
                $display("FAIL reset s%0d: got %h exp 0", i, got_vec(i));
            end
        end
    endtask

    task automatic test_in_order();
        logic [6:0] pv [4] = '{7'h01, 7'h02, 7'h04, 7'h08};
        logic [3:0] ev [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        for (int k = 0; k < 3; k++) step(7'h00, 4'hF);
        for (int k = 0; k < 4; k++) begin
            step(pv[k], ev[k]);
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (got_vec(i) !== exp_vec(i)) begin
                    errors++;
                    $display("FAIL in_order s%0d k%0d: got %h exp %h", i, k, got_vec(i), exp_vec(i));
                end
            end
        end
        checks++;
        if (o_fv[0] !== 1'b0) begin
            errors++;
            $display("FAIL in_order_early_fv: got %b exp 0", o_fv[0]);
        end
        step(7'h00, 4'hF);
        checks++;
        if ({o_fv[0], o_seg[0], o_ds[0]} !== {1'b1, 28'h1010101, 4'h0}) begin
            errors++;
            $display("FAIL in_order_frame: got fv=%b seg=%h ds=%h exp fv=1 seg=1010101 ds=0", o_fv[0], o_seg[0], o_ds[0]);
        end
    endtask

    task automatic test_reverse();
        logic [6:0] pv [4] = '{7'h08, 7'h04, 7'h02, 7'h01};
        logic [3:0] ev [4] = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};
        bit err_seen = 1'b0;
        bit fv_seen = 1'b0;
        for (int k = 0; k < 5; k++) begin
            if (k < 4) step(pv[k], ev[k]); else step(7'h00, 4'hF);
            if (o_err[0] === 1'b1) err_seen = 1'b1;
            if (o_fv[0] === 1'b1) fv_seen = 1'b1;
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (got_vec(i) !== exp_vec(i)) begin
                    errors++;
                    $display("FAIL reverse s%0d k%0d: got %h exp %h", i, k, got_vec(i), exp_vec(i));
                end
            end
        end
        checks++;
`ifdef SEGCAP_ORDER_CHECK_EN
        if ({err_seen, fv_seen} !== 2'b10) begin
            errors++;
            $display("FAIL reverse_order: got err=%b fv=%b exp err=1 fv=0", err_seen, fv_seen);
        end
`else
        if ({err_seen, fv_seen, o_seg[0]} !== {2'b01, 28'h1010101}) begin
            errors++;
            $display("FAIL reverse_any: got err=%b fv=%b seg=%h exp err=0 fv=1 seg=1010101", err_seen, fv_seen, o_seg[0]);
        end
`endif
    endtask

    task automatic test_illegal();
        do_reset();
        step(7'h00, 4'hF);
        step(7'h11, 4'b1110);
        step(7'h22, 4'b1101);
        step(7'h55, 4'b0011);
        checks++;
        if (o_ds[0] !== 4'b0011) begin
            errors++;
            $display("FAIL illegal_pre_ds: got %b exp 0011", o_ds[0]);
        end
        step(7'h00, 4'hF);
        checks++;
        if ({o_err[0], o_ec[0], o_ds[0], o_seg[0], o_fv[0]} !== {1'b1, 8'd1, 4'd0, 28'd0, 1'b0}) begin
            errors++;
            $display("FAIL illegal: got err=%b ec=%0d ds=%b seg=%h exp err=1 ec=1 ds=0 seg=0", o_err[0], o_ec[0], o_ds[0], o_seg[0]);
        end
        step(7'h00, 4'hF);
        checks++;
        if (o_err[0] !== 1'b0) begin
            errors++;
            $display("FAIL illegal_pulse_width: got %b exp 0", o_err[0]);
        end
    endtask

    task automatic test_stable();
        do_reset();
        for (int k = 0; k < 3; k++) step(7'h00, 4'hF);
        for (int k = 0; k < 3; k++) step(7'h3A, 4'b1110);
        for (int k = 0; k < 2; k++) step(7'h15, 4'b1101);
        step(7'h00, 4'hF);
        checks++;
        if (o_ds[1] !== 4'b0001) begin
            errors++;
            $display("FAIL stable_short_run: got ds=%b exp 0001", o_ds[1]);
        end
        for (int k = 0; k < 3; k++) step(7'h15, 4'b1101);
        step(7'h00, 4'hF);
        checks++;
        if ({o_ds[1], o_ec[1]} !== {4'b0011, 8'd0}) begin
            errors++;
            $display("FAIL stable_long_run: got ds=%b ec=%0d exp ds=0011 ec=0", o_ds[1], o_ec[1]);
        end
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (got_vec(i) !== exp_vec(i)) begin
                errors++;
                $display("FAIL stable_model s%0d: got %h exp %h", i, got_vec(i), exp_vec(i));
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [6:0] pv [8] = '{7'h01, 7'h01, 7'h01, 7'h01, 7'h01, 7'h02, 7'h04, 7'h08};
        logic [3:0] ev [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        do_reset();
        step(7'h00, 4'hF);
        for (int k = 0; k < 9; k++) begin
            if (k < 8) step(pv[k], ev[k % 4]); else step(7'h00, 4'hF);
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (got_vec(i) !== exp_vec(i)) begin
                    errors++;
                    $display("FAIL b2b s%0d k%0d: got %h exp %h", i, k, got_vec(i), exp_vec(i));
                end
            end
            if (k == 4 || k == 8) begin
                checks++;
                if ({o_fv[0], o_seg[0]} !== {1'b1, (k == 4) ? 28'h0204081 : 28'h1010101}) begin
                    errors++;
                    $display("FAIL b2b_frame k%0d: got fv=%b seg=%h", k, o_fv[0], o_seg[0]);
                end
            end
        end
        step(7'h00, 4'hF);
        checks++;
        if (o_fv[0] !== 1'b0) begin
            errors++;
            $display("FAIL b2b_fv_pulse: got %b exp 0", o_fv[0]);
        end
    endtask

    task automatic test_saturate();
        logic [3:0] bad [3] = '{4'b0000, 4'b0011, 4'b1010};
        int want;
        do_reset();
        for (int k = 0; k <= 300; k++) begin
            if (k < 300) step(7'(k), bad[k % 3]); else step(7'h00, 4'hF);
            want = (k > 255) ? 255 : k;
            checks++;
            if ({o_err[0], o_ec[0]} !== {(k >= 1), 8'(want)}) begin
                errors++;
                $display("FAIL saturate k%0d: got err=%b ec=%0d exp err=%0d ec=%0d", k, o_err[0], o_ec[0], (k >= 1), want);
            end
        end
        checks++;
        if ({o_ec[0], o_ec[1]} !== {8'hFF, 8'h00}) begin
            errors++;
            $display("FAIL saturate_final: got ec1=%h ec3=%h exp ff 00", o_ec[0], o_ec[1]);
        end
    endtask

    task automatic test_reset_mid();
        logic [6:0] p [4];
        logic [3:0] ev [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        step(7'h00, 4'hF);
        step(7'h2C, 4'b1110);
        step(7'h4B, 4'b1101);
        rst = 1'b1;
        step(7'h00, 4'hF);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (got_vec(i) !== 42'd0) begin
                errors++;
                $display("FAIL reset_mid s%0d: got %h exp 0", i, got_vec(i));
            end
        end
        step(7'h00, 4'hF);
        rst = 1'b0;
        step(7'h00, 4'hF);
        for (int k = 0; k < 4; k++) begin
            p[k] = 7'($urandom);
            step(p[k], ev[k]);
        end
        step(7'h00, 4'hF);
        checks++;
        if ({o_fv[0], o_seg[0]} !== {1'b1, p[3], p[2], p[1], p[0]}) begin
            errors++;
            $display("FAIL reset_mid_frame: got fv=%b seg=%h exp fv=1 seg=%h", o_fv[0], o_seg[0], {p[3], p[2], p[1], p[0]});
        end
    endtask

    task automatic test_random();
        logic [6:0] p;
        logic [3:0] e;
        int kind;
        int hold;
        int n = 0;
        do_reset();
        while (n < 400) begin
            kind = $urandom_range(0, 9);
            p = 7'($urandom);
            if (kind < 2) begin
                e = 4'hF;
            end else if (kind < 8) begin
                e = ~(4'b0001 << $urandom_range(0, 3));
            end else begin
                e = 4'($urandom_range(0, 15));
                while ($countones(e) >= 3) e = 4'($urandom_range(0, 15));
            end
            hold = (kind == 9) ? 18 : $urandom_range(1, 4);
            for (int h = 0; h < hold; h++) begin
                step(p, e);
                n++;
                for (int i = 0; i < 2; i++) begin
                    checks++;
                    if (got_vec(i) !== exp_vec(i)) begin
                        errors++;
                        $display("FAIL random s%0d n%0d: got %h exp %h", i, n, got_vec(i), exp_vec(i));
                    end
                end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 2; i++) model_reset(i);
        @(negedge clk);
        test_reset();
        test_in_order();
        test_reverse();
        test_illegal();
        test_stable();
        test_back_to_back();
        test_saturate();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
